jh_msg_pad: RTL and testbench

Upstream message-formatting stage for the JH hash datapath. Accepts a byte-granular message as a stream of 64-bit words and produces JH-padded 512-bit message blocks. Padding is a single 1 bit, zero fill, and a 128-bit big-endian bit length. Emitted blocks feed the chaining/injection logic that builds each 1024-bit `state_in` for the F8 permutation pipeline.

---
 rtl/jh_pkg.sv | 35 +++
 rtl/jh_pad_merge.sv | 34 +++
 rtl/jh_msg_pad.sv | 153 +++++++++++++++
 tb/tb_jh_msg_pad.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jh_pkg.sv
// Shared constants, state encodings and helpers for the JH message padder.
// Used by jh_msg_pad and jh_pad_merge.
package jh_pkg;

  localparam int JH_BLOCK_W = 512;
  localparam int JH_WORD_W  = 64;
  localparam int JH_LENF_W  = 128;
  localparam int JH_WORDS   = JH_BLOCK_W / JH_WORD_W;

  localparam logic [7:0] JH_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADB,
    LENB
  } jh_state_e;

  // Which extra block, if any, follows the block currently in EMIT.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_PADB,
    PEND_LENB
  } jh_pend_e;

  function automatic logic [JH_WORD_W-1:0] jh_bswap64(input logic [JH_WORD_W-1:0] i_w);
    logic [JH_WORD_W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[8*k +: 8] = i_w[JH_WORD_W-1-8*k -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/jh_pad_merge.sv
// Combinational merge of one 64-bit message word into the 512-bit block buffer,
// inserting the 0x80 pad byte and zero fill when the word ends the message.
module jh_pad_merge
  import jh_pkg::*;
(
  input  logic [JH_BLOCK_W-1:0] i_buf,
  input  logic [JH_WORD_W-1:0]  i_word,
  input  logic [2:0]            i_widx,
  input  logic [3:0]            i_nbytes,
  input  logic                  i_last,
  output logic [JH_BLOCK_W-1:0] o_buf
);

  logic [6:0] w_base;
  logic [6:0] w_pos;

  assign w_base = {1'b0, i_widx, 3'b000};
  // i_nbytes is already clamped to 0..8 by the caller; a full word spans 8 bytes.
  assign w_pos  = w_base + (i_last ? {3'b000, i_nbytes} : 7'd8);

  always_comb begin
    o_buf = i_buf;
    for (int b = 0; b < 64; b++) begin
      if ((b[5:3] == i_widx) && (!i_last || ({1'b0, b[2:0]} < i_nbytes))) begin
        o_buf[JH_BLOCK_W-1-8*b -: 8] = i_word[JH_WORD_W-1-8*(b%8) -: 8];
      end else if (i_last && (7'(b) == w_pos)) begin
        o_buf[JH_BLOCK_W-1-8*b -: 8] = JH_PAD_BYTE;
      end else if (i_last && (7'(b) > w_pos)) begin
        o_buf[JH_BLOCK_W-1-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/jh_msg_pad.sv
// JH message padder: packs 64-bit message words into 512-bit blocks and appends
// 0x80 / zero fill / 128-bit length. Define JH_MSG_PAD_BSWAP_EN for little-endian input words.
module jh_msg_pad
  import jh_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [JH_WORD_W-1:0]  in_data,
  input  logic [3:0]            in_bytes,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [JH_BLOCK_W-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  jh_state_e             r_state;
  jh_pend_e              r_pend;
  logic [2:0]            r_widx;
  logic [LEN_W-1:0]      r_len;
  logic [JH_BLOCK_W-1:0] r_buf;

  jh_state_e             w_state_nxt;
  jh_pend_e              w_pend_nxt;
  logic [2:0]            w_widx_nxt;
  logic [LEN_W-1:0]      w_len_nxt;
  logic [JH_BLOCK_W-1:0] w_buf_nxt;

  logic [JH_WORD_W-1:0]  w_word;
  logic [3:0]            w_nbytes;
  logic [6:0]            w_padpos;
  logic [JH_BLOCK_W-1:0] w_merged;
  logic [JH_LENF_W-1:0]  w_len128;

`ifdef JH_MSG_PAD_BSWAP_EN
  assign w_word = jh_bswap64(in_data);
`else
  assign w_word = in_data;
`endif

  assign w_nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign w_padpos = {1'b0, r_widx, 3'b000} + {3'b000, w_nbytes};
  assign w_len128 = JH_LENF_W'(r_len);

  jh_pad_merge u_merge (
    .i_buf    (r_buf),
    .i_word   (w_word),
    .i_widx   (r_widx),
    .i_nbytes (w_nbytes),
    .i_last   (in_last),
    .o_buf    (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_pend  <= PEND_NONE;
      r_widx  <= '0;
      r_len   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_widx  <= w_widx_nxt;
      r_len   <= w_len_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_widx_nxt  = r_widx;
    w_len_nxt   = r_len;
    w_buf_nxt   = r_buf;
    case (r_state)
      FILL: begin
        if (in_valid) begin
          w_buf_nxt = w_merged;
          if (in_last) begin
            w_len_nxt  = r_len + LEN_W'({w_nbytes, 3'b000});
            w_widx_nxt = '0;
            // An empty tail at a block boundary needs only the 0x80+length block.
            if ((r_widx == 3'd0) && (w_nbytes == 4'd0)) begin
              w_buf_nxt   = r_buf;
              w_state_nxt = PADB;
              w_pend_nxt  = PEND_NONE;
            end else if (w_padpos < 7'd64) begin
              w_state_nxt = EMIT;
              w_pend_nxt  = PEND_LENB;
            end else begin
              w_state_nxt = EMIT;
              w_pend_nxt  = PEND_PADB;
            end
          end else begin
            w_len_nxt = r_len + LEN_W'(JH_WORD_W);
            if (r_widx == 3'(JH_WORDS - 1)) begin
              w_widx_nxt  = '0;
              w_state_nxt = EMIT;
              w_pend_nxt  = PEND_NONE;
            end else begin
              w_widx_nxt = r_widx + 3'd1;
            end
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_buf_nxt  = '0;
          w_widx_nxt = '0;
          w_pend_nxt = PEND_NONE;
          case (r_pend)
            PEND_PADB: w_state_nxt = PADB;
            PEND_LENB: w_state_nxt = LENB;
            default:   w_state_nxt = FILL;
          endcase
        end
      end
      PADB, LENB: begin
        if (out_ready) begin
          w_state_nxt = FILL;
          w_pend_nxt  = PEND_NONE;
          w_widx_nxt  = '0;
          w_len_nxt   = '0;
          w_buf_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_pend_nxt  = PEND_NONE;
      end
    endcase
  end

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state != FILL);
  assign out_last  = (r_state == PADB) || (r_state == LENB);

  always_comb begin
    out_data = '0;
    case (r_state)
      EMIT:    out_data = r_buf;
      PADB:    out_data = {JH_PAD_BYTE, {(JH_BLOCK_W-JH_LENF_W-8){1'b0}}, w_len128};
      LENB:    out_data = {{(JH_BLOCK_W-JH_LENF_W){1'b0}}, w_len128};
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_jh_msg_pad.sv
// Self-checking bench for jh_msg_pad: directed and random messages compared
// against a byte-level padding model, with backpressure and mid-message reset.
module tb_jh_msg_pad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  in_data;
  logic [3:0]   in_bytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]   msg[$];
  logic [511:0] expData[$];
  bit           expLast[$];

  localparam int CYCLE_LIMIT = 3000;

  jh_msg_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to a block boundary (skipped when the
  // message already ends on one), then a block of zeros ending in the bit length.
  task automatic buildExpected();
    logic [7:0]   p[$];
    logic [127:0] lenf;
    logic [511:0] d;
    int           nb;
    p = msg;
    p.push_back(8'h80);
    if ((msg.size() % 64) != 0) begin
      while ((p.size() % 64) != 0) p.push_back(8'h00);
    end
    while ((p.size() % 64) != 48) p.push_back(8'h00);
    lenf = 128'(msg.size()) << 3;
    for (int i = 15; i >= 0; i--) p.push_back(lenf[8*i +: 8]);
    nb = p.size() / 64;
    expData.delete();
    expLast.delete();
    for (int blk = 0; blk < nb; blk++) begin
      d = '0;
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = p[64*blk+j];
      expData.push_back(d);
      expLast.push_back(blk == nb - 1);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  512'(in_ready),  512'(1));
    checkOutput({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    checkOutput({tag, "_out_last"},  512'(out_last),  512'(0));
    checkOutput({tag, "_out_data"},  out_data,        512'(0));
  endtask

  // Sends the message in msg and checks every produced block against the model.
  task automatic applyStimulus(input int holdCycles, input bit extraEmpty);
    logic [63:0] wData[$];
    logic [3:0]  wBytes[$];
    bit          wLast[$];
    logic [63:0] w;
    int          nFull, rem, nWords, wi, hold, cyc, n;
    bit          justLast;

    nFull = msg.size() / 8;
    rem   = msg.size() % 8;
    for (int i = 0; i < nFull; i++) begin
      for (int k = 0; k < 8; k++) w[63-8*k -: 8] = msg[8*i+k];
      wData.push_back(w);
      wLast.push_back(!extraEmpty && rem == 0 && i == nFull - 1);
      wBytes.push_back((!extraEmpty && rem == 0 && i == nFull - 1) ? 4'($urandom_range(8, 15)) : 4'($urandom));
    end
    if (rem != 0 || msg.size() == 0 || extraEmpty) begin
      n = rem;
      for (int k = 0; k < 8; k++) w[63-8*k -: 8] = (k < n) ? msg[8*nFull+k] : 8'($urandom);
      wData.push_back(w);
      wBytes.push_back(4'(n));
      wLast.push_back(1'b1);
    end
    nWords = wData.size();
    buildExpected();

    wi = 0; hold = 0; cyc = 0; justLast = 1'b0;
    while ((wi < nWords || expData.size() > 0 || out_valid) && cyc < CYCLE_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (justLast) begin
        checkOutput("block_latency", 512'(out_valid), 512'(1));
        justLast = 1'b0;
      end
      if (out_valid) begin
        checkOutput("in_ready_low", 512'(in_ready), 512'(0));
        if (expData.size() == 0) begin
          checkOutput("extra_block", 512'(out_valid), 512'(0));
          out_ready = 1'b1;
        end else begin
          checkOutput("out_data", out_data, expData[0]);
          checkOutput("out_last", 512'(out_last), 512'(expLast[0]));
          if (hold < holdCycles) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
            void'(expData.pop_front());
            void'(expLast.pop_front());
            hold = 0;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (in_ready && wi < nWords) begin
        in_valid = 1'b1;
        in_data  = wData[wi];
        in_bytes = wBytes[wi];
        in_last  = wLast[wi];
        justLast = wLast[wi];
        wi++;
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_bytes = 4'($urandom);
        in_last  = 1'($urandom);
      end
    end
    checkOutput("cycle_budget", 512'(cyc < CYCLE_LIMIT), 512'(1));
    checkOutput("blocks_left", 512'(expData.size()), 512'(0));
    checkOutput("in_ready_back", 512'(in_ready), 512'(1));
    checkOutput("idle_out_valid", 512'(out_valid), 512'(0));
  endtask

  task automatic setMsgRandom(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  task automatic setMsgAbc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bytes  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetState("post_reset");

    msg.delete();
    applyStimulus(0, 1'b0);
    setMsgAbc();
    applyStimulus(0, 1'b0);
    setMsgRandom(64);
    applyStimulus(0, 1'b0);
    setMsgRandom(63);
    applyStimulus(0, 1'b0);
    setMsgRandom(64);
    applyStimulus(0, 1'b1);
    setMsgRandom(16);
    applyStimulus(0, 1'b1);

    setMsgAbc();
    applyStimulus(5, 1'b0);
    setMsgRandom(100);
    applyStimulus(5, 1'b0);
    setMsgRandom(128);
    applyStimulus(5, 1'b0);

    // Mid-message reset: three words accepted, then reset, then "abc".
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_bytes = 4'd8;
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checkResetState("mid_reset");
    rst_n = 1'b1;
    setMsgAbc();
    applyStimulus(0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      setMsgRandom(int'($urandom_range(0, 200)));
      applyStimulus(int'($urandom_range(0, 3)), ((msg.size() % 8) == 0) && 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
